bin2bcd_32_seq: RTL

Sequential 32-bit binary to 10-digit packed-BCD converter using shift-and-add-3 (double-dabble), one bit per clock. It sits directly upstream of the 12-digit seven-segment display driver. It supplies the 40-bit BCD digit field, and a valid level that drives the display enable. The output register holds the previous result during a conversion, so the display never shows intermediate values.

---
 rtl/bin2bcd_32_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/bin2bcd_32_seq.sv
// Sequential binary to packed-BCD converter (double-dabble, one bit per clock).
// The BCD output register only changes on completion or reset, so downstream displays never see partial values.
module bin2bcd_32_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   BCD
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic [BCD_W-1:0]   corr_s;

  // Every digit >= 5 gets +3 so the following left shift carries into the next digit correctly.
  function automatic logic [BCD_W-1:0] add3_correct(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  assign corr_s = add3_correct(scratch_q);

  // Next-state and datapath decode for the conversion FSM.
  always_comb begin
    state_d   = state_q;
    bin_sr_d  = bin_sr_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_sr_d  = bin;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        scratch_d = {corr_s[BCD_W-2:0], bin_sr_q[BIN_W-1]};
        bin_sr_d  = {bin_sr_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_sr_q  <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_sr_q  <= bin_sr_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign valid = valid_q;
  assign BCD   = bcd_q;

endmodule
